// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (shift-add-3) feeding a multiplexed 7-segment
// scan driver with leading-zero blanking, sign slot and overflow display.
module bcd_scan_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int PLACES = 6,
    parameter int DIV    = 4000,
    parameter bit BLANK  = 1'b1
) (
    input  logic              clk_original,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic              sign,
    output logic [6:0]        show_num,
    output logic [PLACES-1:0] show_place,
    output logic              upd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [WIDTH+16:0] LIMIT = (WIDTH + 17)'(10 ** DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [BW-1:0]       adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sgn_q, sgn_d;
    logic                ovf_q, ovf_d;
    logic [BW-1:0]       dbcd_q, dbcd_d;
    logic                dsgn_q, dsgn_d;
    logic                dovf_q, dovf_d;
    logic                upd_q, upd_d;
    logic [DW-1:0]       div_q, div_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          num_q, num_d;
    logic [PLACES-1:0]   place_q, place_d;
    logic                tick;
    logic [3:0]          digit;
    logic                zr;
    logic [DIGITS-1:0]   lz;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Converter FSM: capture, WIDTH shift-add-3 steps, atomic commit.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        ovf_d   = ovf_q;
        dbcd_d  = dbcd_q;
        dsgn_d  = dsgn_q;
        dovf_d  = dovf_q;
        upd_d   = 1'b0;
        adj     = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                bin_d   = value;
                sgn_d   = sign;
                ovf_d   = ({17'd0, value} >= LIMIT);
                bcd_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dbcd_d  = bcd_q;
                dsgn_d  = sgn_q;
                dovf_d  = ovf_q;
                upd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Converter and display register state.
    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dbcd_q  <= '0;
            dsgn_q  <= 1'b0;
            dovf_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            ovf_q   <= ovf_d;
            dbcd_q  <= dbcd_d;
            dsgn_q  <= dsgn_d;
            dovf_q  <= dovf_d;
            upd_q   <= upd_d;
        end
    end

    // Refresh divider, scan index and glyph selection; a commit on the
    // same edge as a tick is seen through the display next-state.
    always_comb begin
        tick    = (div_q == DW'(DIV - 1));
        div_d   = tick ? '0 : div_q + DW'(1);
        idx_d   = idx_q;
        num_d   = num_q;
        place_d = place_q;
        digit   = 4'd0;
        zr      = 1'b1;
        lz      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zr    = zr & (dbcd_d[4*i +: 4] == 4'd0);
            lz[i] = zr;
        end
        if (tick) begin
            idx_d   = (idx_q == IW'(DIGITS)) ? '0 : idx_q + IW'(1);
            num_d   = 7'b1111111;
            place_d = '1;
            if (idx_q < IW'(DIGITS)) begin
                digit = dbcd_d[4*idx_q +: 4];
                if (dovf_d) begin
                    num_d          = 7'b0110000;
                    place_d[idx_q] = 1'b0;
                end else if (!(BLANK && idx_q != '0 && lz[idx_q])) begin
                    num_d          = seg7(digit);
                    place_d[idx_q] = 1'b0;
                end
            end else if (dsgn_d) begin
                num_d           = 7'b1111110;
                place_d[DIGITS] = 1'b0;
            end
        end
    end

    // Scan state and registered, glitch-free display outputs.
    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            idx_q   <= '0;
            num_q   <= 7'b1111111;
            place_q <= '1;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            place_q <= place_d;
        end
    end

    assign show_num   = num_q;
    assign show_place = place_q;
    assign upd        = upd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: two parameter sets driven with
// the same random values, checked against an arithmetic display model.
module tb_bcd_scan_display;
    localparam int P = 10;

    typedef struct {
        int v;
        bit s;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] value;
    logic       sign;
    logic [6:0] num_a, num_b;
    logic [5:0] place_a;
    logic [3:0] place_b;
    logic       upd_a, upd_b;

    int    checks   = 0;
    int    failures = 0;
    int    cyc;
    item_t sb[$];

    logic [6:0] GLY[10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                            7'b0000110, 7'b1001100, 7'b0100100,
                            7'b0100000, 7'b0001111, 7'b0000000,
                            7'b0000100};

    bcd_scan_display #(
        .WIDTH(8), .DIGITS(3), .PLACES(6), .DIV(2), .BLANK(1'b1)
    ) dut_a (
        .clk_original(clk), .rst_n(rst_n), .value(value),
        .sign(sign), .show_num(num_a), .show_place(place_a),
        .upd(upd_a)
    );

    bcd_scan_display #(
        .WIDTH(8), .DIGITS(2), .PLACES(4), .DIV(1), .BLANK(1'b0)
    ) dut_b (
        .clk_original(clk), .rst_n(rst_n), .value(value),
        .sign(sign), .show_num(num_b), .show_place(place_b),
        .upd(upd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h",
                     nm, $time, act, exp);
        end
    endtask

    // Expected {segments, places(8b, padded with ones)} for one slot.
    function automatic logic [14:0] slot_exp(input int v, input bit s,
                                             input int d, input bit bl,
                                             input int slot);
        logic [6:0] n;
        logic [7:0] p;
        n = 7'b1111111;
        p = 8'hFF;
        if (slot < d) begin
            if (v >= 10 ** d) begin
                n = 7'b0110000;
                p[slot] = 1'b0;
            end else if (!(bl && slot > 0 && v < 10 ** slot)) begin
                n = GLY[(v / (10 ** slot)) % 10];
                p[slot] = 1'b0;
            end
        end else if (s) begin
            n = 7'b1111110;
            p[d] = 1'b0;
        end
        return {n, p};
    endfunction

    // Monitor: pop on commit, track expected outputs per tick.
    int         dv;
    bit         ds;
    logic [6:0] en_a, en_b;
    logic [7:0] ep_a, ep_b;
    item_t      it;
    always @(negedge clk) begin
        if (!rst_n || cyc == 0) begin
            dv = 0;
            ds = 1'b0;
            en_a = 7'h7F; ep_a = 8'hFF;
            en_b = 7'h7F; ep_b = 8'hFF;
        end else begin
            chk("upd_a", int'(upd_a), int'(cyc % P == 0));
            chk("upd_b", int'(upd_b), int'(cyc % P == 0));
            if (upd_a || upd_b) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    it = sb.pop_front();
                    dv = it.v;
                    ds = it.s;
                end
            end
            if (cyc % 2 == 0)
                {en_a, ep_a} = slot_exp(dv, ds, 3, 1'b1,
                                        ((cyc / 2) - 1) % 4);
            {en_b, ep_b} = slot_exp(dv, ds, 2, 1'b0, (cyc - 1) % 3);
            chk("num_a", int'(num_a), int'(en_a));
            chk("place_a", int'({2'b11, place_a}), int'(ep_a));
            chk("num_b", int'(num_b), int'(en_b));
            chk("place_b", int'({4'hF, place_b}), int'(ep_b));
        end
    end

    task automatic apply(input int v, input bit s);
        item_t x;
        x.v = v;
        x.s = s;
        value = 8'(v);
        sign = s;
        sb.push_back(x);
    endtask

    // Preload next value mid-conversion (must be ignored), then capture.
    task automatic next_period(input int v, input bit s);
        do @(negedge clk); while (cyc % P != 5);
        value = 8'(v);
        sign = s;
        do @(negedge clk); while (cyc % P != 0);
        apply(v, s);
    endtask

    task automatic chk_reset_outs();
        chk("rst_num_a", int'(num_a), 'h7F);
        chk("rst_place_a", int'(place_a), 'h3F);
        chk("rst_upd_a", int'(upd_a), 0);
        chk("rst_num_b", int'(num_b), 'h7F);
        chk("rst_place_b", int'(place_b), 'hF);
        chk("rst_upd_b", int'(upd_b), 0);
    endtask

    int dir_v[10] = '{0, 255, 7, 100, 99, 12, 34, 5, 0, 250};
    bit dir_s[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 1, 1};
    int lv;
    bit ls;

    initial begin
        rst_n = 1'b0;
        value = 8'd0;
        sign  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        apply(dir_v[0], dir_s[0]);
        rst_n = 1'b1;
        for (int i = 1; i < 10; i++) next_period(dir_v[i], dir_s[i]);
        for (int i = 0; i < 25; i++) begin
            lv = int'($urandom_range(0, 255));
            ls = 1'($urandom % 2);
            next_period(lv, ls);
        end
        next_period(lv, ls);
        do @(negedge clk); while (cyc % P != 4);
        #3 rst_n = 1'b0;
        #1 chk_reset_outs();
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_upd_a", int'(upd_a), 0);
            chk("rst_hold_upd_b", int'(upd_b), 0);
        end
        apply(42, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lv = int'($urandom_range(0, 255));
            ls = 1'($urandom % 2);
            next_period(lv, ls);
        end
        next_period(lv, ls);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish",
                 $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
